// File: rtl/axi_mem_arbiter_if.sv
// rtl/axi_mem_arbiter_if.sv - AXI4 master/slave channel bundle for axi_mem_arbiter
interface axi_mem_arbiter_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic [3:0]      arqos;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic [3:0]      awqos;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - N-port cache-miss arbiter onto one AXI4 master; ARB_RR_EN selects round-robin
module axi_mem_arbiter #(
    parameter int N_PORTS   = 2,
    parameter int BURST_LEN = 4,
    parameter int ID_W      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_PORTS-1:0]     req_valid,
    input  logic [N_PORTS-1:0]     req_write,
    input  logic [32*N_PORTS-1:0]  req_addr,
    input  logic [2*N_PORTS-1:0]   req_size,
    input  logic [4*N_PORTS-1:0]   req_strb,
    input  logic [32*N_PORTS-1:0]  req_wdata,
    output logic [N_PORTS-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   rsp_last,
    output logic [N_PORTS-1:0]     req_done,
    axi_mem_arbiter_if.master      axi
);
    localparam int OFF_W = $clog2(BURST_LEN * 4);
    localparam int GW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   grant, sel;
    logic            any_req;
    logic [31:0]     addr_q, wdata_q;
    logic [1:0]      size_q;
    logic [3:0]      strb_q;
    logic            aw_done, w_done;
    logic [4:0]      beat;
    logic            ar_hs, r_hs, aw_hs, w_hs, b_hs, last_beat;
    logic            unused_axi;

    assign any_req   = |req_valid;
    assign ar_hs     = axi.arvalid & axi.arready;
    assign r_hs      = axi.rvalid & axi.rready;
    assign aw_hs     = axi.awvalid & axi.awready;
    assign w_hs      = axi.wvalid & axi.wready;
    assign b_hs      = axi.bvalid & axi.bready;
    assign last_beat = (beat == 5'(BURST_LEN - 1));

`ifdef ARB_RR_EN
    logic [GW-1:0] rr_ptr;

    // Scan downward so the port closest to rr_ptr is the last (winning) match.
    always_comb begin
        sel = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % N_PORTS])
                sel = GW'((int'(rr_ptr) + k) % N_PORTS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (state == S_IDLE && any_req)
            rr_ptr <= (int'(sel) == N_PORTS - 1) ? '0 : sel + 1'b1;
    end
`else
    always_comb begin
        sel = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (req_valid[k])
                sel = GW'(k);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (any_req) state_nxt = req_write[sel] ? S_WR : S_AR;
            S_AR:   if (ar_hs) state_nxt = S_R;
            S_R:    if (r_hs && last_beat) state_nxt = S_DONE;
            S_WR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_B;
            S_B:    if (b_hs) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            strb_q  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            beat    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    beat    <= '0;
                    if (any_req) begin
                        grant   <= sel;
                        addr_q  <= req_addr[32*sel +: 32];
                        wdata_q <= req_wdata[32*sel +: 32];
                        size_q  <= req_size[2*sel +: 2];
                        strb_q  <= req_strb[4*sel +: 4];
                    end
                end
                S_WR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                S_R: if (r_hs) beat <= beat + 5'd1;
                default: ;
            endcase
        end
    end

    // Read address is aligned to the line so the INCR burst fills the whole line.
    assign axi.arid    = ID_W'(0);
    assign axi.araddr  = {addr_q[31:OFF_W], OFF_W'(0)};
    assign axi.arlen   = 8'(BURST_LEN - 1);
    assign axi.arsize  = 3'd2;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arqos   = 4'd0;
    assign axi.arvalid = (state == S_AR);
    assign axi.rready  = (state == S_R);

    assign axi.awid    = ID_W'(0);
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awqos   = 4'd0;
    assign axi.awvalid = (state == S_WR) && !aw_done;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = strb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = (state == S_WR) && !w_done;
    assign axi.bready  = (state == S_B);

    assign rsp_valid = r_hs ? (N_PORTS'(1) << grant) : '0;
    assign rsp_data  = axi.rdata;
    assign rsp_last  = r_hs && last_beat;
    assign req_done  = (state == S_DONE) ? (N_PORTS'(1) << grant) : '0;

    assign unused_axi = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb/tb_axi_mem_arbiter.sv - directed self-checking bench for axi_mem_arbiter
module tb_axi_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_write, rsp_valid, req_done;
    logic [63:0] req_addr, req_wdata;
    logic [3:0]  req_size;
    logic [7:0]  req_strb;
    logic [31:0] rsp_data;
    logic        rsp_last;
    int          n_cmp = 0;
    int          n_err = 0;

    axi_mem_arbiter_if #(.ID_W(4)) axi_bus ();

    axi_mem_arbiter #(.N_PORTS(2), .BURST_LEN(4), .ID_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_strb  (req_strb),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .req_done  (req_done),
        .axi       (axi_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        req_size = '0; req_strb = '0;
        axi_bus.arready = 0; axi_bus.rid = '0; axi_bus.rdata = '0; axi_bus.rresp = '0;
        axi_bus.rlast = 0; axi_bus.rvalid = 0; axi_bus.awready = 0; axi_bus.wready = 0;
        axi_bus.bid = '0; axi_bus.bresp = '0; axi_bus.bvalid = 0;
        repeat (3) tick();
        chk("rst_arvalid", axi_bus.arvalid, 0);
        chk("rst_awvalid", axi_bus.awvalid, 0);
        chk("rst_wvalid", axi_bus.wvalid, 0);
        chk("rst_rready", axi_bus.rready, 0);
        chk("rst_bready", axi_bus.bready, 0);
        chk("rst_rsp", {rsp_valid, rsp_last, req_done}, 0);
        rst = 1'b0;
        tick();

        // Port 0 line fill
        req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h1fc0_0008;
        #1;
        chk("rd0_lat_arvalid", axi_bus.arvalid, 0);
        tick();
        chk("rd0_arvalid", axi_bus.arvalid, 1);
        chk("rd0_araddr", axi_bus.araddr, 32'h1fc0_0000);
        chk("rd0_arlen", axi_bus.arlen, 3);
        chk("rd0_arsize", axi_bus.arsize, 2);
        chk("rd0_arburst", axi_bus.arburst, 1);
        chk("rd0_arid", axi_bus.arid, 0);
        tick();
        chk("rd0_ar_hold", {axi_bus.arvalid, axi_bus.araddr}, {1'b1, 32'h1fc0_0000});
        axi_bus.arready = 1; tick(); axi_bus.arready = 0; #1;
        chk("rd0_ar_drop", axi_bus.arvalid, 0);
        chk("rd0_rready", axi_bus.rready, 1);
        for (int b = 0; b < 4; b++) begin
            axi_bus.rvalid = 1; axi_bus.rdata = 32'ha000_0000 + 32'(b); #1;
            chk("rd0_rsp_valid", rsp_valid, 2'b01);
            chk("rd0_rsp_data", rsp_data, 32'ha000_0000 + 32'(b));
            chk("rd0_rsp_last", rsp_last, (b == 3));
            tick();
        end
        axi_bus.rvalid = 0; req_valid = 2'b00; #1;
        chk("rd0_done", req_done, 2'b01);
        chk("rd0_done_rready", axi_bus.rready, 0);
        tick();
        chk("rd0_done_clear", req_done, 2'b00);
        chk("rd0_idle_arvalid", axi_bus.arvalid, 0);

        // Read with 2-cycle rvalid gaps
        req_valid = 2'b01; req_addr[31:0] = 32'h0000_1234;
        tick();
        chk("gap_araddr", axi_bus.araddr, 32'h0000_1230);
        axi_bus.arready = 1; tick(); axi_bus.arready = 0;
        for (int b = 0; b < 4; b++) begin
            axi_bus.rvalid = 1; axi_bus.rdata = 32'h5500_0000 + 32'(b); #1;
            chk("gap_rsp_valid", rsp_valid, 2'b01);
            chk("gap_rsp_last", rsp_last, (b == 3));
            tick();
            axi_bus.rvalid = 0;
            if (b < 3) begin
                for (int g = 0; g < 2; g++) begin
                    #1;
                    chk("gap_idle_rsp", {rsp_valid, rsp_last}, 3'b000);
                    chk("gap_idle_rready", axi_bus.rready, 1);
                    tick();
                end
            end
        end
        req_valid = 2'b00; #1;
        chk("gap_done", req_done, 2'b01);
        tick();

        // Port 1 write, awready 3 cycles after wready
        req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h8000_0010;
        req_size[3:2] = 2'd1; req_strb[7:4] = 4'b0011; req_wdata[63:32] = 32'hdead_beef;
        tick();
        chk("wr_awvalid", axi_bus.awvalid, 1);
        chk("wr_wvalid", axi_bus.wvalid, 1);
        chk("wr_awaddr", axi_bus.awaddr, 32'h8000_0010);
        chk("wr_awsize", axi_bus.awsize, 1);
        chk("wr_awlen", axi_bus.awlen, 0);
        chk("wr_wstrb", axi_bus.wstrb, 4'b0011);
        chk("wr_wlast", axi_bus.wlast, 1);
        chk("wr_wdata", axi_bus.wdata, 32'hdead_beef);
        axi_bus.wready = 1; tick(); axi_bus.wready = 0; #1;
        chk("wr_wvalid_drop", axi_bus.wvalid, 0);
        chk("wr_awvalid_hold", axi_bus.awvalid, 1);
        tick();
        chk("wr_awvalid_hold2", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}, 3'b100);
        tick();
        axi_bus.awready = 1; tick(); axi_bus.awready = 0; #1;
        chk("wr_aw_drop", axi_bus.awvalid, 0);
        chk("wr_bready", axi_bus.bready, 1);
        tick();
        chk("wr_bready_hold", axi_bus.bready, 1);
        axi_bus.bvalid = 1; tick(); axi_bus.bvalid = 0;
        req_valid = 2'b00; #1;
        chk("wr_done", req_done, 2'b10);
        chk("wr_bready_drop", axi_bus.bready, 0);
        tick();
        chk("wr_done_clear", req_done, 2'b00);

        // Both ports at once: fixed priority serves port 1 first
        req_valid = 2'b11; req_write = 2'b10;
        req_addr = {32'h0000_0200, 32'h0000_0100};
        req_size[3:2] = 2'd2; req_strb[7:4] = 4'hf; req_wdata[63:32] = 32'h1234_5678;
        tick();
        chk("arb_awvalid", axi_bus.awvalid, 1);
        chk("arb_arvalid", axi_bus.arvalid, 0);
        chk("arb_awaddr", axi_bus.awaddr, 32'h0000_0200);
        axi_bus.awready = 1; axi_bus.wready = 1; tick();
        axi_bus.awready = 0; axi_bus.wready = 0; #1;
        chk("arb_bready", axi_bus.bready, 1);
        axi_bus.bvalid = 1; tick(); axi_bus.bvalid = 0;
        req_valid = 2'b01; #1;
        chk("arb_done1", req_done, 2'b10);
        tick();
        chk("arb_bubble", {axi_bus.arvalid, axi_bus.awvalid}, 2'b00);
        tick();
        chk("arb_p0_arvalid", axi_bus.arvalid, 1);
        chk("arb_p0_araddr", axi_bus.araddr, 32'h0000_0100);
        axi_bus.arready = 1; tick(); axi_bus.arready = 0;
        for (int b = 0; b < 4; b++) begin
            axi_bus.rvalid = 1; axi_bus.rdata = 32'h0c00_0000 + 32'(b); #1;
            chk("arb_p0_rsp_valid", rsp_valid, 2'b01);
            tick();
        end
        axi_bus.rvalid = 0; req_valid = 2'b00; #1;
        chk("arb_done0", req_done, 2'b01);
        tick();

        // Reset during beat 2, then a fresh request
        req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h0000_0040;
        tick();
        axi_bus.arready = 1; tick(); axi_bus.arready = 0;
        axi_bus.rvalid = 1; axi_bus.rdata = 32'h1; #1;
        chk("rst_mid_beat1", rsp_valid, 2'b01);
        tick();
        axi_bus.rdata = 32'h2; rst = 1'b1;
        tick();
        rst = 1'b0; axi_bus.rvalid = 0; req_addr[31:0] = 32'h0000_0080; #1;
        chk("rst_mid_rready", axi_bus.rready, 0);
        chk("rst_mid_rsp", {rsp_valid, rsp_last, req_done}, 0);
        chk("rst_mid_arvalid", axi_bus.arvalid, 0);
        tick();
        chk("rst_new_arvalid", axi_bus.arvalid, 1);
        chk("rst_new_araddr", axi_bus.araddr, 32'h0000_0080);
        axi_bus.arready = 1; tick(); axi_bus.arready = 0;
        for (int b = 0; b < 4; b++) begin
            axi_bus.rvalid = 1; axi_bus.rdata = 32'h7700_0000 + 32'(b); #1;
            chk("rst_new_rsp_last", rsp_last, (b == 3));
            tick();
        end
        axi_bus.rvalid = 0; req_valid = 2'b00; #1;
        chk("rst_new_done", req_done, 2'b01);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
